// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and payload type for the register-file write arbiter.
package regfile_arb_pkg;

    localparam int unsigned DEF_NUM_REQ    = 3;
    localparam int unsigned DEF_REG_ADDR_W = 4;
    localparam int unsigned DEF_DATA_W     = 32;

    // Requester slot assignment on the shared write port
    localparam int unsigned REQ_ALU    = 0;
    localparam int unsigned REQ_LOAD   = 1;
    localparam int unsigned REQ_MULDIV = 2;

    // One writeback request: destination index plus data
    typedef struct packed {
        logic [DEF_REG_ADDR_W-1:0] reg_idx;
        logic [DEF_DATA_W-1:0]     data;
    } wb_req_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request / register-file write bus.
// WB_FORWARD_EN adds the read-stage bypass compare ports.
interface regfile_write_arbiter_if import regfile_arb_pkg::*; #(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W
);
    logic                         stall;
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*REG_ADDR_W-1:0] req_reg;
    logic [NUM_REQ*DATA_W-1:0]    req_data;
    logic                         regWrite;
    logic [REG_ADDR_W-1:0]        writeRegister;
    logic [DATA_W-1:0]            writeData;
    logic                         busy;
`ifdef WB_FORWARD_EN
    logic [REG_ADDR_W-1:0]        readRegister1;
    logic [REG_ADDR_W-1:0]        readRegister2;
    logic                         fwdHit1;
    logic                         fwdHit2;
    logic [DATA_W-1:0]            fwdData;
`endif

    // Requesters and register file side
    modport master (
`ifdef WB_FORWARD_EN
        output readRegister1, readRegister2,
        input  fwdHit1, fwdHit2, fwdData,
`endif
        output stall, req_valid, req_reg, req_data,
        input  req_ready, regWrite, writeRegister, writeData, busy
    );

    // Arbiter side
    modport slave (
`ifdef WB_FORWARD_EN
        input  readRegister1, readRegister2,
        output fwdHit1, fwdHit2, fwdData,
`endif
        input  stall, req_valid, req_reg, req_data,
        output req_ready, regWrite, writeRegister, writeData, busy
    );

endinterface

// File: rtl/regfile_write_arbiter_rr_grant.sv
// Round-robin one-hot grant: first set request at or above ptr, wrapping.
module rr_grant #(
    parameter int unsigned N     = 3,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     grant
);

    logic [N-1:0] mask;
    logic [N-1:0] masked;

    // Isolate the lowest set bit of a vector
    function automatic logic [N-1:0] lowest(input logic [N-1:0] v);
        return v & (~v + N'(1));
    endfunction

    // Prefer requests at or above the pointer, else wrap to the lowest one
    always_comb begin
        mask   = '0;
        masked = '0;
        grant  = '0;
        for (int i = 0; i < int'(N); i++) begin
            mask[i] = (i >= int'(ptr));
        end
        masked = req & mask;
        if (en) begin
            grant = (|masked) ? lowest(masked) : lowest(req);
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between
// writeback requesters; winner is registered and written one cycle later.
// Optional read-stage bypass compare under WB_FORWARD_EN.
module regfile_write_arbiter import regfile_arb_pkg::*; #(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W
) (
    input logic                    clock,
    input logic                    reset,
    regfile_write_arbiter_if.slave bus
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("regfile_write_arbiter: NUM_REQ must be in 2..8");
    end

    logic [PTR_W-1:0]      ptr;
    logic [PTR_W-1:0]      next_ptr;
    logic [NUM_REQ-1:0]    grant;
    logic                  transfer;
    logic [REG_ADDR_W-1:0] sel_reg;
    logic [DATA_W-1:0]     sel_data;
    logic                  wr_en;
    logic [REG_ADDR_W-1:0] wr_reg;
    logic [DATA_W-1:0]     wr_data;

    // No grants while stalled or held in reset
    rr_grant #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr_grant (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .en    (!bus.stall && !reset),
        .grant (grant)
    );

    assign transfer = |grant;

    // Mux the winner's payload and compute the pointer after its transfer
    always_comb begin
        sel_reg  = '0;
        sel_data = '0;
        next_ptr = ptr;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant[i]) begin
                sel_reg  = bus.req_reg[i*REG_ADDR_W +: REG_ADDR_W];
                sel_data = bus.req_data[i*DATA_W +: DATA_W];
                next_ptr = (i == int'(NUM_REQ) - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    // Write stage register; register-0 writes are consumed but suppressed
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr     <= '0;
            wr_en   <= 1'b0;
            wr_reg  <= '0;
            wr_data <= '0;
        end else begin
            ptr   <= next_ptr;
            wr_en <= transfer && (sel_reg != '0);
            if (transfer && (sel_reg != '0)) begin
                wr_reg  <= sel_reg;
                wr_data <= sel_data;
            end
        end
    end

    assign bus.req_ready     = grant;
    assign bus.regWrite      = wr_en;
    assign bus.writeRegister = wr_reg;
    assign bus.writeData     = wr_data;
    assign bus.busy          = (|bus.req_valid) || wr_en;

`ifdef WB_FORWARD_EN
    // Bypass the write issued this cycle to the read stage
    assign bus.fwdHit1 = wr_en && (wr_reg == bus.readRegister1) && (bus.readRegister1 != '0);
    assign bus.fwdHit2 = wr_en && (wr_reg == bus.readRegister2) && (bus.readRegister2 != '0);
    assign bus.fwdData = wr_data;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed vector bench for regfile_write_arbiter (forward checks under WB_FORWARD_EN).
module tb_regfile_write_arbiter;
    import regfile_arb_pkg::*;

    logic clock = 1'b0;
    logic reset;

    regfile_write_arbiter_if #(.NUM_REQ(3), .REG_ADDR_W(4), .DATA_W(32)) bus ();

    regfile_write_arbiter #(.NUM_REQ(3), .REG_ADDR_W(4), .DATA_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          stall;
        logic [2:0]    valid;
        wb_req_t [2:0] req;
        logic [2:0]    exp_ready;
        logic          exp_busy;
        logic          exp_we;
        logic [3:0]    exp_wr;
        logic [31:0]   exp_wd;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic st, input logic [2:0] v,
                                input logic [3:0] r0, input logic [31:0] d0,
                                input logic [3:0] r1, input logic [31:0] d1,
                                input logic [3:0] r2, input logic [31:0] d2,
                                input logic [2:0] rdy, input logic bsy,
                                input logic we, input logic [3:0] wr, input logic [31:0] wd);
        vec_t x;
        x.stall = st;
        x.valid = v;
        x.req[REQ_ALU]    = '{reg_idx: r0, data: d0};
        x.req[REQ_LOAD]   = '{reg_idx: r1, data: d1};
        x.req[REQ_MULDIV] = '{reg_idx: r2, data: d2};
        x.exp_ready = rdy;
        x.exp_busy  = bsy;
        x.exp_we    = we;
        x.exp_wr    = wr;
        x.exp_wd    = wd;
        return x;
    endfunction

    task automatic drive(input vec_t v);
        bus.stall     = v.stall;
        bus.req_valid = v.valid;
        for (int i = 0; i < 3; i++) begin
            bus.req_reg[i*4 +: 4]   = v.req[i].reg_idx;
            bus.req_data[i*32 +: 32] = v.req[i].data;
        end
    endtask

    initial begin
        vec_t idle;
        vec_t all3;
        idle = mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
        all3 = mk(0, 3'b111, 1, 32'h11, 2, 32'h22, 3, 32'h33, 3'b001, 1, 1, 1, 32'h11);

        //           st  valid   r0 d0             r1 d1             r2 d2        ready  busy we wr wd
        vecs[0]  = mk(0, 3'b000, 0, 0,             0, 0,             0, 0,        3'b000, 0, 0, 0, 0);
        vecs[1]  = mk(0, 3'b111, 1, 32'h11,        2, 32'h22,        3, 32'h33,   3'b001, 1, 1, 1, 32'h11);
        vecs[2]  = mk(0, 3'b111, 1, 32'h11,        2, 32'h22,        3, 32'h33,   3'b010, 1, 1, 2, 32'h22);
        vecs[3]  = mk(0, 3'b111, 1, 32'h11,        2, 32'h22,        3, 32'h33,   3'b100, 1, 1, 3, 32'h33);
        vecs[4]  = mk(0, 3'b111, 1, 32'h11,        2, 32'h22,        3, 32'h33,   3'b001, 1, 1, 1, 32'h11);
        vecs[5]  = mk(0, 3'b000, 0, 0,             0, 0,             0, 0,        3'b000, 1, 0, 1, 32'h11);
        vecs[6]  = mk(0, 3'b010, 0, 0,             5, 32'hDEADBEEF,  0, 0,        3'b010, 1, 1, 5, 32'hDEADBEEF);
        vecs[7]  = mk(0, 3'b000, 0, 0,             0, 0,             0, 0,        3'b000, 1, 0, 5, 32'hDEADBEEF);
        vecs[8]  = mk(0, 3'b001, 0, 32'h1234,      0, 0,             0, 0,        3'b001, 1, 0, 5, 32'hDEADBEEF);
        vecs[9]  = mk(0, 3'b011, 4, 32'h44,        6, 32'h66,        0, 0,        3'b010, 1, 1, 6, 32'h66);
        vecs[10] = mk(0, 3'b011, 4, 32'h44,        6, 32'h66,        0, 0,        3'b001, 1, 1, 4, 32'h44);
        vecs[11] = mk(1, 3'b100, 0, 0,             0, 0,             9, 32'h99,   3'b000, 1, 0, 4, 32'h44);
        vecs[12] = mk(1, 3'b100, 0, 0,             0, 0,             9, 32'h99,   3'b000, 1, 0, 4, 32'h44);
        vecs[13] = mk(1, 3'b100, 0, 0,             0, 0,             9, 32'h99,   3'b000, 1, 0, 4, 32'h44);
        vecs[14] = mk(0, 3'b100, 0, 0,             0, 0,             9, 32'h99,   3'b100, 1, 1, 9, 32'h99);

        reset = 1'b1;
        drive(idle);
`ifdef WB_FORWARD_EN
        bus.readRegister1 = '0;
        bus.readRegister2 = '0;
`endif
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset regWrite", 32'(bus.regWrite), 0);
        check("reset writeRegister", 32'(bus.writeRegister), 0);
        check("reset writeData", bus.writeData, 0);
        check("reset req_ready", 32'(bus.req_ready), 0);
        check("reset busy", 32'(bus.busy), 0);
        bus.req_valid = 3'b111;
        #1;
        check("ready held low in reset", 32'(bus.req_ready), 0);
        bus.req_valid = 3'b000;
        @(negedge clock);
        reset = 1'b0;

        // Table: inputs applied at negedge, grant checked mid-cycle, write after the edge
        for (int i = 0; i < NV; i++) begin
            @(negedge clock);
            drive(vecs[i]);
            #1;
            check($sformatf("v%0d req_ready", i), 32'(bus.req_ready), 32'(vecs[i].exp_ready));
            check($sformatf("v%0d busy", i), 32'(bus.busy), 32'(vecs[i].exp_busy));
            @(posedge clock);
            #1;
            check($sformatf("v%0d regWrite", i), 32'(bus.regWrite), 32'(vecs[i].exp_we));
            check($sformatf("v%0d writeRegister", i), 32'(bus.writeRegister), 32'(vecs[i].exp_wr));
            check($sformatf("v%0d writeData", i), bus.writeData, vecs[i].exp_wd);
        end

        // In-flight write dropped by asynchronous reset; pointer returns to 0
        @(negedge clock);
        drive(mk(0, 3'b001, 10, 32'hAA, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clock);
        #1;
        check("inflight regWrite", 32'(bus.regWrite), 1);
        check("inflight writeRegister", 32'(bus.writeRegister), 10);
        drive(idle);
        #1;
        reset = 1'b1;
        #1;
        check("async reset regWrite", 32'(bus.regWrite), 0);
        check("async reset writeRegister", 32'(bus.writeRegister), 0);
        check("async reset writeData", bus.writeData, 0);
        @(negedge clock);
        reset = 1'b0;
        drive(all3);
        #1;
        check("ptr reset req_ready", 32'(bus.req_ready), 32'b001);
        @(posedge clock);
        #1;
        check("ptr reset writeRegister", 32'(bus.writeRegister), 1);
        check("ptr reset writeData", bus.writeData, 32'h11);

`ifdef WB_FORWARD_EN
        // Bypass compare against the registered write
        @(negedge clock);
        drive(mk(0, 3'b001, 7, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        bus.readRegister1 = 4'd7;
        bus.readRegister2 = 4'd0;
        @(posedge clock);
        #1;
        check("fwdHit1", 32'(bus.fwdHit1), 1);
        check("fwdHit2", 32'(bus.fwdHit2), 0);
        check("fwdData", bus.fwdData, 32'hA5A5A5A5);
`endif

        @(negedge clock);
        drive(idle);
        @(posedge clock);
        #1;
        check("final regWrite idle", 32'(bus.regWrite), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
